// File: rtl/rv32_pipe_ctrl_pkg.sv
// Shared definitions for the rv32 pipeline sequencer and the register blocks it controls.
package rv32_pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned STATE_W    = 2;

  // addi x0, x0, 0 -- bubble loaded into a flushed register block
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ABORT    = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_rb1;
    logic stall_rb2;
    logic flush_rb1;
    logic flush_rb2;
  } pipe_ctrl_t;

  // A bubble loaded into a block makes holding that block meaningless, so flush wins.
  function automatic pipe_ctrl_t resolve_ctrl(input pipe_ctrl_t c);
    pipe_ctrl_t r;
    r           = c;
    r.stall_rb1 = c.stall_rb1 & ~c.flush_rb1;
    r.stall_rb2 = c.stall_rb2 & ~c.flush_rb2;
    return r;
  endfunction

endpackage

// File: rtl/rv32_pipe_ctrl_if.sv
// Control/status bundle between the pipeline sequencer and the datapath.
interface rv32_pipe_ctrl_if
  import rv32_pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic [REG_ADDR_W-1:0] id_rs1_addr_in;
  logic [REG_ADDR_W-1:0] id_rs2_addr_in;
  logic                  id_rs1_used_in;
  logic                  id_rs2_used_in;
  logic [REG_ADDR_W-1:0] ex_rd_addr_in;
  logic                  ex_load_in;
  logic                  branch_taken_in;
  logic                  dmem_req_in;
  logic                  dmem_ack_in;

  logic                  stall_pc_out;
  logic                  stall_rb1_out;
  logic                  stall_rb2_out;
  logic                  flush_rb1_out;
  logic                  flush_rb2_out;
  logic                  bus_err_out;
  logic [STATE_W-1:0]    state_out;
  logic [CNT_W-1:0]      stall_cnt_out;

  modport master (
    output id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in,
           ex_rd_addr_in, ex_load_in, branch_taken_in, dmem_req_in, dmem_ack_in,
    input  stall_pc_out, stall_rb1_out, stall_rb2_out, flush_rb1_out, flush_rb2_out,
           bus_err_out, state_out, stall_cnt_out
  );

  modport slave (
    input  id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in,
           ex_rd_addr_in, ex_load_in, branch_taken_in, dmem_req_in, dmem_ack_in,
    output stall_pc_out, stall_rb1_out, stall_rb2_out, flush_rb1_out, flush_rb2_out,
           bus_err_out, state_out, stall_cnt_out
  );

endinterface

// File: rtl/rv32_hazard_detect.sv
// Load-use compare between the stage-1 sources and the stage-2 load destination.
module rv32_hazard_detect
  import rv32_pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  load,
  output logic                  hazard_c
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rs1_hit  = rs1_used && (rs1_addr == rd_addr);
  assign rs2_hit  = rs2_used && (rs2_addr == rd_addr);
  assign hazard_c = load && (rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/rv32_pipe_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flushes, memory-wait freeze with timeout abort.
module rv32_pipe_ctrl
  import rv32_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             reset_in,
  rv32_pipe_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                load_use;
  logic                mem_pending;
  logic                bus_err;
  pipe_ctrl_t          ctrl_raw;
  pipe_ctrl_t          ctrl;

  rv32_hazard_detect u_hazard (
    .rs1_addr (bus.id_rs1_addr_in),
    .rs2_addr (bus.id_rs2_addr_in),
    .rs1_used (bus.id_rs1_used_in),
    .rs2_used (bus.id_rs2_used_in),
    .rd_addr  (bus.ex_rd_addr_in),
    .load     (bus.ex_load_in),
    .hazard_c (load_use)
  );

  assign mem_pending = bus.dmem_req_in && !bus.dmem_ack_in;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state and raw controls; priority within RUN is mem stall > branch > load-use.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ctrl_raw = '0;
    bus_err  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_pending) begin
          ctrl_raw.stall_pc  = 1'b1;
          ctrl_raw.stall_rb1 = 1'b1;
          ctrl_raw.stall_rb2 = 1'b1;
          state_d            = ST_MEM_WAIT;
          wait_d             = WAIT_W'(1);
        end else if (bus.branch_taken_in) begin
          ctrl_raw.flush_rb1 = 1'b1;
          ctrl_raw.flush_rb2 = 1'b1;
        end else if (load_use) begin
          ctrl_raw.stall_pc  = 1'b1;
          ctrl_raw.stall_rb1 = 1'b1;
          ctrl_raw.flush_rb2 = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // The ack cycle itself still holds the pipe; ack beats a coincident timeout.
        ctrl_raw.stall_pc  = 1'b1;
        ctrl_raw.stall_rb1 = 1'b1;
        ctrl_raw.stall_rb2 = 1'b1;
        if (bus.dmem_ack_in) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ST_ABORT;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      ST_ABORT: begin
        ctrl_raw.flush_rb1 = 1'b1;
        ctrl_raw.flush_rb2 = 1'b1;
        bus_err            = 1'b1;
        state_d            = ST_RUN;
        wait_d             = '0;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Reset fills the pipe with bubbles immediately, independent of the clock.
  always_comb begin
    ctrl = resolve_ctrl(ctrl_raw);
    if (reset_in) begin
      ctrl           = '0;
      ctrl.flush_rb1 = 1'b1;
      ctrl.flush_rb2 = 1'b1;
    end
    stall_cnt_d = stall_cnt_q + (ctrl.stall_pc ? CNT_W'(1) : CNT_W'(0));
  end

  assign bus.stall_pc_out  = ctrl.stall_pc;
  assign bus.stall_rb1_out = ctrl.stall_rb1;
  assign bus.stall_rb2_out = ctrl.stall_rb2;
  assign bus.flush_rb1_out = ctrl.flush_rb1;
  assign bus.flush_rb2_out = ctrl.flush_rb2;
  assign bus.bus_err_out   = bus_err && !reset_in;
  assign bus.state_out     = state_q;
  assign bus.stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// Directed bench for rv32_pipe_ctrl: reset, load-use, branch, memory wait, timeout, zero-wait.
module tb_rv32_pipe_ctrl;
  import rv32_pipe_ctrl_pkg::*;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  rv32_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rv32_pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs_ctrl();
    return {bus.stall_pc_out, bus.stall_rb1_out, bus.stall_rb2_out,
            bus.flush_rb1_out, bus.flush_rb2_out};
  endfunction

  task automatic idle();
    bus.id_rs1_addr_in  = '0;
    bus.id_rs2_addr_in  = '0;
    bus.id_rs1_used_in  = 1'b0;
    bus.id_rs2_used_in  = 1'b0;
    bus.ex_rd_addr_in   = '0;
    bus.ex_load_in      = 1'b0;
    bus.branch_taken_in = 1'b0;
    bus.dmem_req_in     = 1'b0;
    bus.dmem_ack_in     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives a cycle; hz sets up a load-use match on rs1 against rd=7.
  task automatic drive(input logic req, input logic ack, input logic br, input logic hz);
    idle();
    bus.dmem_req_in     = req;
    bus.dmem_ack_in     = ack;
    bus.branch_taken_in = br;
    if (hz) begin
      bus.ex_load_in     = 1'b1;
      bus.ex_rd_addr_in  = 5'd7;
      bus.id_rs1_addr_in = 5'd7;
      bus.id_rs1_used_in = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_tests++;
    if (obs_ctrl() !== 5'b00011 || bus.state_out !== 2'd0 || bus.stall_cnt_out !== '0
        || bus.bus_err_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: ctrl=%b state=%0d cnt=%0d err=%b, want ctrl=00011 state=0 cnt=0 err=0",
               obs_ctrl(), bus.state_out, bus.stall_cnt_out, bus.bus_err_out);
    end
    rst = 1'b0;
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (bus.state_out !== 2'd1 || bus.stall_cnt_out !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL reset_pre_wait: state=%0d cnt=%0d, want state=1 cnt=1",
               bus.state_out, bus.stall_cnt_out);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (obs_ctrl() !== 5'b00011 || bus.state_out !== 2'd0 || bus.stall_cnt_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: ctrl=%b state=%0d cnt=%0d, want ctrl=00011 state=0 cnt=0",
               obs_ctrl(), bus.state_out, bus.stall_cnt_out);
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_tests++;
    if (obs_ctrl() !== 5'b00000 || bus.state_out !== 2'd0 || bus.stall_cnt_out !== '0) begin
      n_fail++;
      $display("FAIL reset_release: ctrl=%b state=%0d cnt=%0d, want ctrl=00000 state=0 cnt=0",
               obs_ctrl(), bus.state_out, bus.stall_cnt_out);
    end
    exp_cnt = 0;
  endtask

  task automatic test_load_use();
    // {load, rd, rs1, rs2, rs1_used, rs2_used, expected hazard}
    logic       v_ld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] v_rd [6] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 5'd9};
    logic [4:0] v_r1 [6] = '{5'd5, 5'd1, 5'd0, 5'd5, 5'd5, 5'd9};
    logic [4:0] v_r2 [6] = '{5'd2, 5'd5, 5'd0, 5'd3, 5'd5, 5'd9};
    logic       v_u1 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       v_u2 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       v_hz [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle();
      bus.ex_load_in     = v_ld[i];
      bus.ex_rd_addr_in  = v_rd[i];
      bus.id_rs1_addr_in = v_r1[i];
      bus.id_rs2_addr_in = v_r2[i];
      bus.id_rs1_used_in = v_u1[i];
      bus.id_rs2_used_in = v_u2[i];
      @(negedge clk);
      n_tests++;
      if (obs_ctrl() !== (v_hz[i] ? 5'b11001 : 5'b00000) || bus.state_out !== 2'd0
          || bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL load_use[%0d]: ctrl=%b state=%0d cnt=%0d, want ctrl=%b state=0 cnt=%0d",
                 i, obs_ctrl(), bus.state_out, bus.stall_cnt_out,
                 (v_hz[i] ? 5'b11001 : 5'b00000), exp_cnt);
      end
      if (v_hz[i]) exp_cnt++;
    end
  endtask

  task automatic test_branch();
    logic br [3] = '{1'b1, 1'b1, 1'b0};
    logic hz [3] = '{1'b1, 1'b0, 1'b0};
    logic [4:0] e_ctrl [3] = '{5'b00011, 5'b00011, 5'b00000};
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, br[i], hz[i]);
      @(negedge clk);
      n_tests++;
      if (obs_ctrl() !== e_ctrl[i] || bus.state_out !== 2'd0
          || bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL branch[%0d]: ctrl=%b state=%0d cnt=%0d, want ctrl=%b state=0 cnt=%0d",
                 i, obs_ctrl(), bus.state_out, bus.stall_cnt_out, e_ctrl[i], exp_cnt);
      end
      if (e_ctrl[i][4]) exp_cnt++;
    end
  endtask

  task automatic test_mem_wait();
    // branch in cycle 2 must be ignored while frozen
    logic req [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ack [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic br  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0] e_ctrl [5] = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00000};
    logic [1:0] e_st   [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(req[i], ack[i], br[i], 1'b0);
      @(negedge clk);
      n_tests++;
      if (obs_ctrl() !== e_ctrl[i] || bus.state_out !== e_st[i] || bus.bus_err_out !== 1'b0
          || bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL mem_wait[%0d]: ctrl=%b state=%0d err=%b cnt=%0d, want ctrl=%b state=%0d err=0 cnt=%0d",
                 i, obs_ctrl(), bus.state_out, bus.bus_err_out, bus.stall_cnt_out,
                 e_ctrl[i], e_st[i], exp_cnt);
      end
      if (e_ctrl[i][4]) exp_cnt++;
    end
  endtask

  task automatic test_timeout();
    logic req [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] e_ctrl [7] = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100,
                               5'b00011, 5'b00000};
    logic [1:0] e_st   [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    logic       e_err  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive(req[i], 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (obs_ctrl() !== e_ctrl[i] || bus.state_out !== e_st[i] || bus.bus_err_out !== e_err[i]
          || bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL timeout[%0d]: ctrl=%b state=%0d err=%b cnt=%0d, want ctrl=%b state=%0d err=%b cnt=%0d",
                 i, obs_ctrl(), bus.state_out, bus.bus_err_out, bus.stall_cnt_out,
                 e_ctrl[i], e_st[i], e_err[i], exp_cnt);
      end
      if (e_ctrl[i][4]) exp_cnt++;
    end
  endtask

  task automatic test_ack_on_timeout();
    logic req [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ack [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] e_ctrl [6] = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00000};
    logic [1:0] e_st   [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(req[i], ack[i], 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (obs_ctrl() !== e_ctrl[i] || bus.state_out !== e_st[i] || bus.bus_err_out !== 1'b0
          || bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL ack_on_timeout[%0d]: ctrl=%b state=%0d err=%b cnt=%0d, want ctrl=%b state=%0d err=0 cnt=%0d",
                 i, obs_ctrl(), bus.state_out, bus.bus_err_out, bus.stall_cnt_out,
                 e_ctrl[i], e_st[i], exp_cnt);
      end
      if (e_ctrl[i][4]) exp_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    // zero-wait, zero-wait with load-use, two 1-wait accesses back to back, branch, idle
    logic req [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic ack [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic br  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic hz  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0] e_ctrl [8] = '{5'b00000, 5'b11001, 5'b11100, 5'b11100,
                               5'b11100, 5'b11100, 5'b00011, 5'b00000};
    logic [1:0] e_st   [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(req[i], ack[i], br[i], hz[i]);
      @(negedge clk);
      n_tests++;
      if (obs_ctrl() !== e_ctrl[i] || bus.state_out !== e_st[i] || bus.bus_err_out !== 1'b0
          || bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: ctrl=%b state=%0d err=%b cnt=%0d, want ctrl=%b state=%0d err=0 cnt=%0d",
                 i, obs_ctrl(), bus.state_out, bus.bus_err_out, bus.stall_cnt_out,
                 e_ctrl[i], e_st[i], exp_cnt);
      end
      if (e_ctrl[i][4]) exp_cnt++;
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_tests++;
    if (bus.stall_cnt_out !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL final_cnt: cnt=%0d, want %0d", bus.stall_cnt_out, exp_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_ack_on_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
